// File: rtl/rx_intf_pl_to_m_axis_gen2.sv
// Packet-to-AXI-Stream front end for the rx_intf DMA path.
// Emits a 2- or 4-word header per received packet, forwards the payload,
// tracks a per-packet sequence number and a saturating drop counter, recovers
// from a missing tlast with a watchdog, and coalesces S2MM completion
// interrupts. A raw IQ bypass feeds the stream outputs straight from rf_iq.
module rx_intf_pl_to_m_axis_gen2 #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int TSF_TIMER_WIDTH        = 64,
  parameter int RSSI_HALF_DB_WIDTH     = 11,
  parameter int GPIO_STATUS_WIDTH      = 8,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter int TIMEOUT_WIDTH          = 13
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              src_sel,
  input  logic                              hdr_mode,
  input  logic                              sig_valid,
  input  logic                              ht_unsupport,
  input  logic                              ht_sgi,
  input  logic [7:0]                        pkt_rate,
  input  logic [15:0]                       pkt_len,
  input  logic [RSSI_HALF_DB_WIDTH-1:0]     rssi_half_db_lock_by_sig_valid,
  input  logic [GPIO_STATUS_WIDTH-1:0]      gpio_status_lock_by_sig_valid,
  input  logic [TSF_TIMER_WIDTH-1:0]        tsf_runtime_val,
  input  logic                              tsf_pulse_1M,
  input  logic                              block_rx_dma_to_ps,
  input  logic                              block_rx_dma_to_ps_valid,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] data_from_acc,
  input  logic                              data_ready_from_acc,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] rf_iq,
  input  logic                              rf_iq_valid,
  input  logic                              m_axis_tlast,
  input  logic                              s2mm_intr,
  input  logic                              tlast_timeout_en,
  input  logic [TIMEOUT_WIDTH-1:0]          tlast_timeout_top,
  input  logic [7:0]                        intr_coalesce_num,
  input  logic [TIMEOUT_WIDTH-1:0]          intr_holdoff_top,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] data_to_m_axis_out,
  output logic                              data_ready_to_m_axis_out,
  output logic                              start_1trans_to_m_axis,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] monitor_num_dma_symbol_to_ps,
  output logic                              m_axis_rst,
  output logic                              m_axis_tlast_auto_recover,
  output logic [15:0]                       rx_pkt_sn,
  output logic [15:0]                       rx_drop_cnt,
  output logic                              rx_pkt_intr
);

  localparam int DW = C_M00_AXIS_TDATA_WIDTH;
  localparam int MW = MAX_BIT_NUM_DMA_SYMBOL;
  localparam int TW = TIMEOUT_WIDTH;

  localparam logic [63:0] HDR_W3 = 64'h0011223344556677;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_FILT = 3'd2,
    S_XFER = 3'd3,
    S_RST  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            hdr_last_q, hdr_last_d;
  logic [TSF_TIMER_WIDTH-1:0] tsf_q;
  logic [63:0]           w1_q, w1_d;
  logic [DW-1:0]         data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  start_q, start_d;
  logic [MW-1:0]         monitor_q, monitor_d;
  logic [2:0]            rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]         wd_q, wd_d;
  logic                  recover_q, recover_d;
  logic [15:0]           sn_q, sn_d;
  logic [15:0]           drop_q, drop_d;
  logic                  drop_evt;
  logic                  go_rst;

  logic                  s2mm_q;
  logic [7:0]            pending_q, pending_d;
  logic [TW-1:0]         holdoff_q, holdoff_d;
  logic                  intr_q, intr_d;

  logic [16:0]           len_round;
  logic [TW-1:0]         wd_inc;
  logic                  wd_expired;
  logic [7:0]            coalesce_thr;
  logic                  s2mm_edge;
  logic                  fire;

  // Rate bits 6:4 carry no information in the header layout.
  logic unused_rate_bits;
  assign unused_rate_bits = ^pkt_rate[6:4];

  assign len_round  = {1'b0, pkt_len} + 17'd7;
  assign wd_inc     = (tsf_pulse_1M && (wd_q != {TW{1'b1}})) ? wd_q + 1'b1 : wd_q;
  assign wd_expired = tlast_timeout_en && (wd_q > tlast_timeout_top);

  // Packet sequencer: header emission, filter decision, transfer, m_axis reset.
  // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hdr_last_d = hdr_last_q;
    w1_d       = w1_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    start_d    = 1'b0;
    monitor_d  = monitor_q;
    rst_cnt_d  = rst_cnt_q;
    wd_d       = '0;
    recover_d  = 1'b0;
    sn_d       = sn_q;
    drop_evt   = 1'b0;
    go_rst     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sig_valid) begin
          if (ht_unsupport) begin
            drop_evt = 1'b1;
          end else begin
            // Word 0 is loaded here so it appears the cycle after sig_valid.
            hdr_last_d = hdr_mode ? 2'd3 : 2'd1;
            monitor_d  = MW'(len_round[16:3]) + (hdr_mode ? MW'(4) : MW'(2));
            w1_d       = {10'd0, ht_sgi, pkt_rate[7], pkt_rate[3:0], pkt_len, 8'd0,
                          gpio_status_lock_by_sig_valid, 5'd0, rssi_half_db_lock_by_sig_valid};
            data_d     = DW'(tsf_runtime_val);
            valid_d    = 1'b1;
            idx_d      = 2'd1;
            state_d    = S_HDR;
          end
        end
      end

      S_HDR: begin
        valid_d = 1'b1;
        case (idx_q)
          2'd1:    data_d = DW'(w1_q);
          2'd2:    data_d = DW'({sn_q + 16'd1, drop_q, 32'd0});
          2'd3:    data_d = DW'(HDR_W3);
          default: data_d = DW'(tsf_q);
        endcase
        idx_d = idx_q + 2'd1;
        if (idx_q == hdr_last_q) state_d = S_FILT;
      end

      S_FILT: begin
        data_d  = data_from_acc;
        valid_d = data_ready_from_acc;
        wd_d    = wd_inc;
        // A stuck stream takes priority over a late filter decision.
        if (wd_expired) begin
          recover_d = 1'b1;
          drop_evt  = 1'b1;
          go_rst    = 1'b1;
        end else if (block_rx_dma_to_ps_valid) begin
          if (!block_rx_dma_to_ps) begin
            sn_d    = sn_q + 16'd1;
            start_d = 1'b1;
            wd_d    = '0;
            state_d = S_XFER;
          end else begin
            drop_evt = 1'b1;
            go_rst   = 1'b1;
          end
        end
      end

      S_XFER: begin
        data_d  = data_from_acc;
        valid_d = data_ready_from_acc;
        wd_d    = wd_inc;
        if (wd_expired) begin
          recover_d = 1'b1;
          drop_evt  = 1'b1;
          go_rst    = 1'b1;
        end else if (m_axis_tlast) begin
          state_d = S_IDLE;
        end
      end

      S_RST: begin
        monitor_d = '0;
        rst_cnt_d = rst_cnt_q + 3'd1;
        if (rst_cnt_q == 3'd7) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (go_rst) begin
      state_d   = S_RST;
      rst_cnt_d = '0;
      valid_d   = 1'b0;
      monitor_d = '0;
    end

    // A SIG arriving mid-packet is discarded and counted.
    if (sig_valid && (state_q != S_IDLE)) drop_evt = 1'b1;

    // Coincident drop sources collapse into one increment; the count sticks at full scale.
    drop_d = (drop_evt && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  assign coalesce_thr = (intr_coalesce_num == 8'd0) ? 8'd1 : intr_coalesce_num;
  assign s2mm_edge    = s2mm_intr & ~s2mm_q;
  assign fire         = (pending_q >= coalesce_thr) ||
                        ((pending_q != 8'd0) && (holdoff_q > intr_holdoff_top));

  // Interrupt coalescing: count completions, fire on count or holdoff expiry.
  always_comb begin
    intr_d    = fire;
    pending_d = fire ? {7'd0, s2mm_edge} : pending_q + {7'd0, s2mm_edge};
    holdoff_d = holdoff_q;
    if (fire || (pending_q == 8'd0)) begin
      holdoff_d = '0;
    end else if (tsf_pulse_1M && (holdoff_q != {TW{1'b1}})) begin
      holdoff_d = holdoff_q + 1'b1;
    end
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      hdr_last_q <= '0;
      tsf_q      <= '0;
      w1_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      monitor_q  <= '0;
      rst_cnt_q  <= '0;
      wd_q       <= '0;
      recover_q  <= 1'b0;
      sn_q       <= '0;
      drop_q     <= '0;
      s2mm_q     <= 1'b0;
      pending_q  <= '0;
      holdoff_q  <= '0;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hdr_last_q <= hdr_last_d;
      if (sig_valid) tsf_q <= tsf_runtime_val;
      w1_q       <= w1_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      monitor_q  <= monitor_d;
      rst_cnt_q  <= rst_cnt_d;
      wd_q       <= wd_d;
      recover_q  <= recover_d;
      sn_q       <= sn_d;
      drop_q     <= drop_d;
      s2mm_q     <= s2mm_intr;
      pending_q  <= pending_d;
      holdoff_q  <= holdoff_d;
      intr_q     <= intr_d;
    end
  end

  // Bypass is combinational; it is gated by reset so outputs read 0 while rst is high.
  assign data_to_m_axis_out           = src_sel ? (rst ? '0 : rf_iq) : data_q;
  assign data_ready_to_m_axis_out     = src_sel ? (rf_iq_valid & ~rst) : valid_q;
  assign start_1trans_to_m_axis       = start_q & ~src_sel;
  assign monitor_num_dma_symbol_to_ps = monitor_q;
  assign m_axis_rst                   = (state_q == S_RST);
  assign m_axis_tlast_auto_recover    = recover_q;
  assign rx_pkt_sn                    = sn_q;
  assign rx_drop_cnt                  = drop_q;
  assign rx_pkt_intr                  = intr_q;

endmodule

// File: tb/tb_rx_intf_pl_to_m_axis_gen2.sv
// Directed bench for rx_intf_pl_to_m_axis_gen2: a table of header vectors
// plus hand-written sequences for blocking, watchdog, coalescing, bypass,
// drop saturation and mid-packet reset.
module tb_rx_intf_pl_to_m_axis_gen2;

  typedef struct packed {
    logic        hdr_mode;
    logic [15:0] len;
    logic [7:0]  rate;
    logic        sgi;
    logic [10:0] rssi;
    logic [7:0]  gpio;
    logic [13:0] exp_mon;
    logic [63:0] exp_w1;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        src_sel;
  logic        hdr_mode;
  logic        sig_valid;
  logic        ht_unsupport;
  logic        ht_sgi;
  logic [7:0]  pkt_rate;
  logic [15:0] pkt_len;
  logic [10:0] rssi;
  logic [7:0]  gpio;
  logic [63:0] tsf_runtime_val;
  logic        tsf_pulse_1M;
  logic        block_rx_dma_to_ps;
  logic        block_rx_dma_to_ps_valid;
  logic [63:0] data_from_acc;
  logic        data_ready_from_acc;
  logic [63:0] rf_iq;
  logic        rf_iq_valid;
  logic        m_axis_tlast;
  logic        s2mm_intr;
  logic        tlast_timeout_en;
  logic [12:0] tlast_timeout_top;
  logic [7:0]  intr_coalesce_num;
  logic [12:0] intr_holdoff_top;
  logic [63:0] data_out;
  logic        valid_out;
  logic        start_out;
  logic [13:0] monitor;
  logic        m_axis_rst;
  logic        auto_recover;
  logic [15:0] rx_pkt_sn;
  logic [15:0] rx_drop_cnt;
  logic        rx_pkt_intr;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_sn   = 16'd0;
  logic [15:0] exp_drop = 16'd0;
  int intr_cnt;
  int rec_cnt;
  int mrst_cnt;
  vec_t vecs [5];

  rx_intf_pl_to_m_axis_gen2 dut (
    .clk                            (clk),
    .rst                            (rst),
    .src_sel                        (src_sel),
    .hdr_mode                       (hdr_mode),
    .sig_valid                      (sig_valid),
    .ht_unsupport                   (ht_unsupport),
    .ht_sgi                         (ht_sgi),
    .pkt_rate                       (pkt_rate),
    .pkt_len                        (pkt_len),
    .rssi_half_db_lock_by_sig_valid (rssi),
    .gpio_status_lock_by_sig_valid  (gpio),
    .tsf_runtime_val                (tsf_runtime_val),
    .tsf_pulse_1M                   (tsf_pulse_1M),
    .block_rx_dma_to_ps             (block_rx_dma_to_ps),
    .block_rx_dma_to_ps_valid       (block_rx_dma_to_ps_valid),
    .data_from_acc                  (data_from_acc),
    .data_ready_from_acc            (data_ready_from_acc),
    .rf_iq                          (rf_iq),
    .rf_iq_valid                    (rf_iq_valid),
    .m_axis_tlast                   (m_axis_tlast),
    .s2mm_intr                      (s2mm_intr),
    .tlast_timeout_en               (tlast_timeout_en),
    .tlast_timeout_top              (tlast_timeout_top),
    .intr_coalesce_num              (intr_coalesce_num),
    .intr_holdoff_top               (intr_holdoff_top),
    .data_to_m_axis_out             (data_out),
    .data_ready_to_m_axis_out       (valid_out),
    .start_1trans_to_m_axis         (start_out),
    .monitor_num_dma_symbol_to_ps   (monitor),
    .m_axis_rst                     (m_axis_rst),
    .m_axis_tlast_auto_recover      (auto_recover),
    .rx_pkt_sn                      (rx_pkt_sn),
    .rx_drop_cnt                    (rx_drop_cnt),
    .rx_pkt_intr                    (rx_pkt_intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the bench can never hang.
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one clock and tally the pulse-type outputs.
  task automatic tick_mon();
    tick();
    if (rx_pkt_intr)  intr_cnt++;
    if (auto_recover) rec_cnt++;
    if (m_axis_rst)   mrst_cnt++;
  endtask

  // Issue SIG and check every header word as it appears.
  task automatic send_hdr(input vec_t v, input logic [63:0] tsf);
    hdr_mode        = v.hdr_mode;
    pkt_len         = v.len;
    pkt_rate        = v.rate;
    ht_sgi          = v.sgi;
    rssi            = v.rssi;
    gpio            = v.gpio;
    tsf_runtime_val = tsf;
    ht_unsupport    = 1'b0;
    sig_valid       = 1'b1;
    tick();
    sig_valid = 1'b0;
    check("w0_tsf", data_out, tsf);
    check("w0_valid", {63'd0, valid_out}, 64'd1);
    check("monitor", {50'd0, monitor}, {50'd0, v.exp_mon});
    tick();
    check("w1_fields", data_out, v.exp_w1);
    if (v.hdr_mode) begin
      tick();
      check("w2_sn_drop", data_out, {exp_sn + 16'd1, exp_drop, 32'd0});
      tick();
      check("w3_const", data_out, 64'h0011223344556677);
    end
  endtask

  // Present the filter decision with the first payload word.
  task automatic decide(input logic blk, input logic [63:0] payload);
    data_from_acc            = payload;
    data_ready_from_acc      = 1'b1;
    block_rx_dma_to_ps       = blk;
    block_rx_dma_to_ps_valid = 1'b1;
    tick();
    block_rx_dma_to_ps_valid = 1'b0;
    data_ready_from_acc      = 1'b0;
    if (!blk) begin
      exp_sn = exp_sn + 16'd1;
      check("start_pulse", {63'd0, start_out}, 64'd1);
      check("payload0", data_out, payload);
      check("sn_after_accept", {48'd0, rx_pkt_sn}, {48'd0, exp_sn});
    end else begin
      exp_drop = exp_drop + 16'd1;
      check("blk_valid_low", {63'd0, valid_out}, 64'd0);
      check("blk_monitor_zero", {50'd0, monitor}, 64'd0);
      mrst_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        if (m_axis_rst) mrst_cnt++;
        tick();
      end
      check("blk_mrst_cycles", 64'(mrst_cnt), 64'd8);
      check("blk_sn_same", {48'd0, rx_pkt_sn}, {48'd0, exp_sn});
      check("blk_drop", {48'd0, rx_drop_cnt}, {48'd0, exp_drop});
    end
  endtask

  // One more payload word then tlast back to IDLE.
  task automatic finish_xfer(input logic [63:0] payload);
    data_from_acc       = payload;
    data_ready_from_acc = 1'b1;
    tick();
    data_ready_from_acc = 1'b0;
    check("start_one_cycle", {63'd0, start_out}, 64'd0);
    check("payload1", data_out, payload);
    m_axis_tlast = 1'b1;
    tick();
    m_axis_tlast = 1'b0;
    check("valid_after_tlast", {63'd0, valid_out}, 64'd0);
  endtask

  task automatic s2mm_edge_pulse();
    s2mm_intr = 1'b1;
    tick_mon();
    s2mm_intr = 1'b0;
    tick_mon();
    tick_mon();
  endtask

  task automatic us_tick();
    tsf_pulse_1M = 1'b1;
    tick_mon();
    tsf_pulse_1M = 1'b0;
    tick_mon();
    tick_mon();
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'd13,    8'h8B, 1'b0, 11'h155, 8'h3C, 14'd4,    64'h001B_000D_003C_0155};
    vecs[1] = '{1'b1, 16'd16,    8'h0F, 1'b1, 11'h7FF, 8'hFF, 14'd6,    64'h002F_0010_00FF_07FF};
    vecs[2] = '{1'b0, 16'd0,     8'h80, 1'b1, 11'h000, 8'h00, 14'd2,    64'h0030_0000_0000_0000};
    vecs[3] = '{1'b1, 16'hFFFF,  8'h7A, 1'b0, 11'h400, 8'h81, 14'd8196, 64'h000A_FFFF_0081_0400};
    vecs[4] = '{1'b0, 16'd8,     8'h00, 1'b0, 11'h001, 8'h01, 14'd3,    64'h0000_0008_0001_0001};

    rst = 1'b1;
    src_sel = 1'b1;
    hdr_mode = 1'b0; sig_valid = 1'b0; ht_unsupport = 1'b0; ht_sgi = 1'b0;
    pkt_rate = '0; pkt_len = '0; rssi = '0; gpio = '0; tsf_runtime_val = '0;
    tsf_pulse_1M = 1'b0; block_rx_dma_to_ps = 1'b0; block_rx_dma_to_ps_valid = 1'b0;
    data_from_acc = '0; data_ready_from_acc = 1'b0;
    rf_iq = 64'hFEED_FACE_CAFE_BABE; rf_iq_valid = 1'b1;
    m_axis_tlast = 1'b0; s2mm_intr = 1'b0;
    tlast_timeout_en = 1'b0; tlast_timeout_top = 13'd5;
    intr_coalesce_num = 8'd3; intr_holdoff_top = 13'h1FFF;
    intr_cnt = 0; rec_cnt = 0; mrst_cnt = 0;

    // Reset state, including the bypass path held at zero.
    #12;
    check("rst_bypass_data", data_out, 64'd0);
    check("rst_bypass_valid", {63'd0, valid_out}, 64'd0);
    src_sel = 1'b0; rf_iq_valid = 1'b0;
    #1;
    check("rst_monitor", {50'd0, monitor}, 64'd0);
    check("rst_sn_drop", {32'd0, rx_pkt_sn, rx_drop_cnt}, 64'd0);
    check("rst_pulses", {59'd0, start_out, m_axis_rst, auto_recover, rx_pkt_intr, valid_out}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Header table: every entry is accepted and closed with tlast.
    for (int i = 0; i < 5; i++) begin
      send_hdr(vecs[i], 64'h0123_4567_89AB_CD00 + 64'(i));
      decide(1'b0, 64'hA000_0000_0000_0000 + 64'(i));
      finish_xfer(64'hB000_0000_0000_0000 + 64'(i));
      tick();
    end

    // Blocked packet: drop counts, m_axis reset for 8 cycles, sn holds.
    send_hdr(vecs[1], 64'h5555_0000_0000_0001);
    decide(1'b1, 64'hC0C0_C0C0_C0C0_C0C0);
    tick();

    // Watchdog: no tlast, limit 5 us.
    tlast_timeout_en = 1'b1;
    tlast_timeout_top = 13'd5;
    send_hdr(vecs[0], 64'h7777_0000_0000_0002);
    decide(1'b0, 64'hD000_0000_0000_0001);
    rec_cnt = 0; mrst_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      us_tick();
      if (k == 5) check("wd_not_early", 64'(rec_cnt), 64'd0);
    end
    repeat (12) tick_mon();
    exp_drop = exp_drop + 16'd1;
    check("wd_recover_once", 64'(rec_cnt), 64'd1);
    check("wd_mrst_cycles", 64'(mrst_cnt), 64'd8);
    check("wd_drop", {48'd0, rx_drop_cnt}, {48'd0, exp_drop});
    tlast_timeout_en = 1'b0;
    // FSM is back in IDLE: a new packet is accepted normally.
    send_hdr(vecs[4], 64'h8888_0000_0000_0003);
    decide(1'b0, 64'hE000_0000_0000_0001);
    finish_xfer(64'hE000_0000_0000_0002);
    tick();

    // Count-based coalescing, threshold 3.
    intr_coalesce_num = 8'd3;
    intr_holdoff_top = 13'h1FFF;
    intr_cnt = 0;
    s2mm_edge_pulse();
    s2mm_edge_pulse();
    check("coal3_none_early", 64'(intr_cnt), 64'd0);
    s2mm_edge_pulse();
    check("coal3_fire", 64'(intr_cnt), 64'd1);
    repeat (4) tick_mon();
    check("coal3_single", 64'(intr_cnt), 64'd1);

    // Threshold 0 behaves as 1: every edge fires.
    intr_coalesce_num = 8'd0;
    intr_cnt = 0;
    for (int e = 0; e < 3; e++) s2mm_edge_pulse();
    repeat (3) tick_mon();
    check("coal0_each_edge", 64'(intr_cnt), 64'd3);

    // Holdoff: one pending edge fires after more than 4 us.
    intr_coalesce_num = 8'd8;
    intr_holdoff_top = 13'd4;
    intr_cnt = 0;
    s2mm_edge_pulse();
    for (int k = 1; k <= 5; k++) begin
      us_tick();
      if (k == 4) check("holdoff_not_early", 64'(intr_cnt), 64'd0);
    end
    check("holdoff_fire", 64'(intr_cnt), 64'd1);

    // Raw IQ bypass is combinational.
    src_sel = 1'b1;
    rf_iq = 64'hDEAD_BEEF_0123_4567;
    rf_iq_valid = 1'b1;
    #1;
    check("bypass_data", data_out, 64'hDEAD_BEEF_0123_4567);
    check("bypass_valid_start", {62'd0, valid_out, start_out}, 64'd2);
    rf_iq_valid = 1'b0;
    #1;
    check("bypass_valid_low", {63'd0, valid_out}, 64'd0);
    src_sel = 1'b0;
    tick();

    // Drop counter saturation via unsupported-HT rejects.
    ht_unsupport = 1'b1;
    sig_valid = 1'b1;
    repeat (int'(16'hFFFE - exp_drop)) tick();
    check("drop_preset", {48'd0, rx_drop_cnt}, 64'h0000_0000_0000_FFFE);
    repeat (3) tick();
    sig_valid = 1'b0;
    ht_unsupport = 1'b0;
    check("drop_saturated", {48'd0, rx_drop_cnt}, 64'h0000_0000_0000_FFFF);
    check("drop_sn_same", {48'd0, rx_pkt_sn}, {48'd0, exp_sn});
    tick();

    // Reset mid-header aborts immediately.
    hdr_mode = 1'b1; pkt_len = 16'd40; tsf_runtime_val = 64'h9999_0000_0000_0004;
    sig_valid = 1'b1;
    tick();
    sig_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", {63'd0, valid_out}, 64'd0);
    check("midrst_data", data_out, 64'd0);
    check("midrst_counters", {18'd0, monitor, rx_pkt_sn}, 64'd0);
    check("midrst_drop", {48'd0, rx_drop_cnt}, 64'd0);
    tick();
    rst = 1'b0;
    exp_sn = 16'd0;
    exp_drop = 16'd0;
    tick();
    send_hdr(vecs[1], 64'hAAAA_0000_0000_0005);
    decide(1'b0, 64'hF000_0000_0000_0001);
    finish_xfer(64'hF000_0000_0000_0002);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
